ltc2387_sequencer: RTL and testbench
====================================

# ltc2387_sequencer

Frame sequencer and decimator for the dual-channel LTC2387 capture path. Issues the CNV pulse at a programmable sample period, then after the conversion time pulses `burst_start` to the deserializer, which drives its `clkout_dec` input. It waits a bounded time for the deserializer's `adc_valid`, counts missed frames, and averages 2^k accepted samples per channel before presenting them downstream.

## Interface
- `CNT_W`, 16: width of `period` and the period counter.
- `CNV_HIGH`, 2: CNV pulse width, in cycles.
- `CONV_CYCLES`, 16: cycles from CNV rise to `burst_start`.
- `TIMEOUT`, 32: maximum cycles in READ waiting for `adc_valid_in`.
- `MAX_LOG2_DEC`, 8: largest decimation exponent.

- `clk`  in  1  sample-domain clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  run request.
- `period`  in  CNT_W  frame length in cycles; clamped to PERIOD_MIN = CONV_CYCLES+TIMEOUT+1.
- `log2_dec`  in  4  decimation exponent k; values above MAX_LOG2_DEC are clamped.
- `clear_timeout`  in  1  clears `timeout_cnt`.
- `adc0_in`, `adc1_in`  in  18  signed samples from the deserializer.
- `adc_valid_in`  in  1  deserializer sample strobe.
- `cnv`  out  1  ADC conversion start.
- `burst_start`  out  1  one-cycle request for a read clock burst.
- `out_data0`, `out_data1`  out  18  signed averaged samples.
- `out_valid`  out  1  one-cycle strobe; there is no backpressure.
- `busy`  out  1  high whenever the state is not IDLE.
- `timeout_cnt`  out  16  saturating count of missed frames.

## Operation
- States:
  - **IDLE**: waiting for a run request.
  - **CONVERT**: CNV issued, conversion in progress.
  - **READ**: waiting for the sample.
  - **HOLD**: waiting out the rest of the period.
- **IDLE → CONVERT**: `enable` is sampled high. The period counter `pcnt` is set to 0, and `period_eff = max(period, PERIOD_MIN)` is latched.
- **CONVERT**:
  - `cnv` = 1 while `pcnt` < CNV_HIGH.
  - At `pcnt` == CONV_CYCLES: `burst_start` = 1 for one cycle, the wait counter clears, and the state moves to READ.
- **READ**:
  - `adc_valid_in` high: both samples are accepted and the state moves to HOLD.
  - `TIMEOUT` cycles pass without a valid: `timeout_cnt` += 1 (saturating at 0xFFFF), the frame is discarded and does not count toward decimation, and the state moves to HOLD.
- **HOLD**: at `pcnt` == `period_eff`−1:
  - `enable` high: go to CONVERT with `pcnt` = 0, relatch `period_eff`.
  - `enable` low: go to IDLE.
- `adc_valid_in` outside READ is ignored.
- `enable` dropping mid-frame: the frame completes, and the block then stops at the period boundary.
- **Decimation**:
  - k is latched only at frame start while `acc_cnt` == 0.
  - The accumulators are signed, ACC_W = 18+MAX_LOG2_DEC = 26 bits.
  - On an accepted sample with `acc_cnt` == 2^k−1: `out_data` = (acc + sample) >>> k, truncated to 18 bits (floor), then `out_valid`; acc and `acc_cnt` clear.
  - On any other accepted sample: acc += sample, `acc_cnt` += 1.
- `clear_timeout` together with an increment in the same cycle: the result is 1.
- `rst` at any time: next cycle state = IDLE, all counters and accumulators are 0, and all outputs are 0.

## Timing
- Reset values: `cnv`, `burst_start`, `out_valid`, `busy` = 0; `out_data0/1` = 0; `timeout_cnt` = 0.
- Frame cycle 0 is the first cycle with `cnv` high. It is one cycle after `enable` is sampled in IDLE, or the cycle after the HOLD end.
- The next CNV rises exactly `period_eff` cycles after the previous one.
- `burst_start` is high at frame cycle CONV_CYCLES.
- `out_valid` and `out_data` are registered, one cycle after the completing `adc_valid_in`.
- `busy` goes high together with `cnv` and low on the cycle after the final HOLD cycle.
- `cnv`, `burst_start` and `busy` are all registered outputs.

## Structure
- Package `ltc2387_pkg`:
  - state enum (IDLE/CONVERT/READ/HOLD);
  - ADC_W = 18, MAX_LOG2_DEC, ACC_W;
  - PERIOD_MIN as a function of the parameters.
- Sub-module `ltc2387_avg`: one per channel. Contains the accumulator and shift, driven by a shared `acc_cnt`/k from the sequencer.
- The top level holds the FSM, `pcnt`, the wait counter and `timeout_cnt`.

## Test plan
- **Reset**: assert `rst` for 3 cycles mid-run → all outputs 0, `busy` = 0, and no `cnv` until `enable` is seen again.
- **Single-sample path**: `period` = 100, k = 0; the model returns valid 12 cycles after `burst_start` with `adc0` = 131071, `adc1` = −131072 → `cnv` high for 2 cycles every 100 cycles, `burst_start` at frame cycle 16, `out_valid` 1 cycle after valid with identical data.
- **Decimation**: k = 2.
  - Samples 4, 5, 6, 7 → one `out_valid` per 4 frames, value 5.
  - Samples −1, −1, −1, −2 → −2.
- **Period clamp**: `period` = 10 → CNV rises every 49 cycles.
- **Timeout**: valid withheld in one frame → `timeout_cnt` = 1, the frame is excluded from the average, and a late valid during HOLD is ignored. `clear_timeout` coincident with a timeout → `timeout_cnt` = 1.
- **Stop mid-frame**: `enable` dropped during READ → the frame completes, `busy` falls after cycle `period_eff`−1, and no further CNV is issued.

Source files
------------

// File: rtl/ltc2387_pkg.sv
// Shared types and constants for the LTC2387 frame sequencer and its per-channel averagers.
package ltc2387_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_READ,
    ST_HOLD
  } state_t;

  localparam int ADC_W        = 18;
  localparam int MAX_LOG2_DEC = 8;
  localparam int ACC_W        = ADC_W + MAX_LOG2_DEC;

  // Shortest legal frame: conversion, a full read window, and one HOLD cycle.
  function automatic int period_min(input int conv_cycles, input int timeout);
    return conv_cycles + timeout + 1;
  endfunction

endpackage

// File: rtl/ltc2387_avg.sv
// ltc2387_avg: one channel's signed accumulator; dumps (sum >>> k) when the shared sample count wraps.
module ltc2387_avg #(
  parameter int MAX_LOG2_DEC = ltc2387_pkg::MAX_LOG2_DEC
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  i_accept,
  input  logic                                  i_last,
  input  logic [3:0]                            i_k,
  input  logic signed [ltc2387_pkg::ADC_W-1:0]  i_sample,
  output logic signed [ltc2387_pkg::ADC_W-1:0]  o_data
);
  import ltc2387_pkg::*;

  // Wide enough for 2^MAX_LOG2_DEC full-scale samples without overflow.
  localparam int SUM_W = ADC_W + MAX_LOG2_DEC;

  logic signed [SUM_W-1:0] r_acc;
  logic signed [SUM_W-1:0] w_sum;
  logic signed [ADC_W-1:0] r_data;

  // Sized cast of a signed operand sign-extends the sample into the accumulator width.
  assign w_sum  = r_acc + SUM_W'(i_sample);
  assign o_data = r_data;

  // Accumulate accepted samples; on the last one, emit the floored mean and restart.
  always_ff @(posedge clk) begin
    // NOTE: the accumulator is reset too, otherwise the first average after reset would carry stale sum.
    if (rst) begin
      r_acc  <= '0;
      r_data <= '0;
    end else if (i_accept) begin
      if (i_last) begin
        r_data <= ADC_W'(w_sum >>> i_k);
        r_acc  <= '0;
      end else begin
        r_acc  <= w_sum;
      end
    end
  end

endmodule

// File: rtl/ltc2387_sequencer.sv
// ltc2387_sequencer: CNV/burst frame sequencer with bounded read wait, missed-frame count and 2^k decimation.
module ltc2387_sequencer #(
  parameter int CNT_W        = 16,
  parameter int CNV_HIGH     = 2,
  parameter int CONV_CYCLES  = 16,
  parameter int TIMEOUT      = 32,
  parameter int MAX_LOG2_DEC = ltc2387_pkg::MAX_LOG2_DEC
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  enable,
  input  logic [CNT_W-1:0]                      period,
  input  logic [3:0]                            log2_dec,
  input  logic                                  clear_timeout,
  input  logic signed [ltc2387_pkg::ADC_W-1:0]  adc0_in,
  input  logic signed [ltc2387_pkg::ADC_W-1:0]  adc1_in,
  input  logic                                  adc_valid_in,
  output logic                                  cnv,
  output logic                                  burst_start,
  output logic signed [ltc2387_pkg::ADC_W-1:0]  out_data0,
  output logic signed [ltc2387_pkg::ADC_W-1:0]  out_data1,
  output logic                                  out_valid,
  output logic                                  busy,
  output logic [15:0]                           timeout_cnt
);
  import ltc2387_pkg::*;

  localparam int               PMIN         = period_min(CONV_CYCLES, TIMEOUT);
  localparam logic [CNT_W-1:0] PERIOD_MIN_C = CNT_W'(PMIN);
  // cnv is registered, so its next value is decided one count ahead of the frame cycle.
  localparam logic [CNT_W-1:0] CNV_LAST     = CNT_W'(CNV_HIGH - 1);
  // burst_start is registered too: raise it on the edge that ends cycle CONV_CYCLES-1.
  localparam logic [CNT_W-1:0] BURST_AT     = CNT_W'(CONV_CYCLES - 1);
  localparam int               WAIT_W       = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST   = WAIT_W'(TIMEOUT - 1);
  localparam int               DEC_W        = MAX_LOG2_DEC;

  state_t             r_state;
  logic [CNT_W-1:0]   r_pcnt;
  logic [CNT_W-1:0]   r_period_eff;
  logic [WAIT_W-1:0]  r_wcnt;
  logic [3:0]         r_k;
  logic [DEC_W-1:0]   r_acc_cnt;
  logic [15:0]        r_timeout_cnt;
  logic               r_cnv;
  logic               r_burst_start;
  logic               r_out_valid;
  logic               r_busy;

  logic [CNT_W-1:0]   w_period_eff;
  logic [3:0]         w_k_clamp;
  logic [DEC_W:0]     w_dec_mask;
  logic               w_last;
  logic               w_accept;
  logic               w_timeout;
  logic               w_frame_end;
  logic               w_frame_start;

  assign w_period_eff  = (period < PERIOD_MIN_C) ? PERIOD_MIN_C : period;
  assign w_k_clamp     = (log2_dec > 4'(MAX_LOG2_DEC)) ? 4'(MAX_LOG2_DEC) : log2_dec;
  assign w_dec_mask    = ((DEC_W + 1)'(1) << r_k) - (DEC_W + 1)'(1);
  assign w_last        = ({1'b0, r_acc_cnt} == w_dec_mask);
  assign w_accept      = (r_state == ST_READ) && adc_valid_in;
  assign w_timeout     = (r_state == ST_READ) && !adc_valid_in && (r_wcnt == WAIT_LAST);
  assign w_frame_end   = (r_state == ST_HOLD) && (r_pcnt == r_period_eff - CNT_W'(1));
  assign w_frame_start = enable && ((r_state == ST_IDLE) || w_frame_end);

  assign cnv         = r_cnv;
  assign burst_start = r_burst_start;
  assign out_valid   = r_out_valid;
  assign busy        = r_busy;
  assign timeout_cnt = r_timeout_cnt;

  // Frame FSM plus its counters and registered strobes.
  always_ff @(posedge clk) begin
    // NOTE: every register here uses <= so all updates see the values from before the edge.
    if (rst) begin
      r_state       <= ST_IDLE;
      r_pcnt        <= '0;
      r_period_eff  <= '0;
      r_wcnt        <= '0;
      r_k           <= '0;
      r_acc_cnt     <= '0;
      r_timeout_cnt <= '0;
      r_cnv         <= 1'b0;
      r_burst_start <= 1'b0;
      r_out_valid   <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_burst_start <= 1'b0;
      r_out_valid   <= w_accept && w_last;

      if (w_accept) begin
        r_acc_cnt <= w_last ? '0 : r_acc_cnt + DEC_W'(1);
      end

      // A clear landing on the same cycle as a miss still records that miss.
      if (w_timeout) begin
        if (clear_timeout)                 r_timeout_cnt <= 16'd1;
        else if (r_timeout_cnt != 16'hFFFF) r_timeout_cnt <= r_timeout_cnt + 16'd1;
      end else if (clear_timeout) begin
        r_timeout_cnt <= '0;
      end

      if (w_frame_start) begin
        r_state      <= ST_CONVERT;
        r_pcnt       <= '0;
        r_period_eff <= w_period_eff;
        r_cnv        <= 1'b1;
        r_busy       <= 1'b1;
        // Changing k mid-average would mix scales, so it only moves on a fresh average.
        if (r_acc_cnt == '0) r_k <= w_k_clamp;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_pcnt <= '0;
          end
          ST_CONVERT: begin
            r_pcnt <= r_pcnt + CNT_W'(1);
            r_cnv  <= (r_pcnt < CNV_LAST);
            if (r_pcnt == BURST_AT) begin
              r_burst_start <= 1'b1;
              r_wcnt        <= '0;
              r_state       <= ST_READ;
            end
          end
          ST_READ: begin
            r_pcnt <= r_pcnt + CNT_W'(1);
            if (adc_valid_in || (r_wcnt == WAIT_LAST)) r_state <= ST_HOLD;
            else                                       r_wcnt  <= r_wcnt + WAIT_W'(1);
          end
          ST_HOLD: begin
            if (w_frame_end) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_pcnt  <= '0;
            end else begin
              r_pcnt  <= r_pcnt + CNT_W'(1);
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  ltc2387_avg #(
    .MAX_LOG2_DEC (MAX_LOG2_DEC)
  ) u_avg0 (
    .clk      (clk),
    .rst      (rst),
    .i_accept (w_accept),
    .i_last   (w_last),
    .i_k      (r_k),
    .i_sample (adc0_in),
    .o_data   (out_data0)
  );

  ltc2387_avg #(
    .MAX_LOG2_DEC (MAX_LOG2_DEC)
  ) u_avg1 (
    .clk      (clk),
    .rst      (rst),
    .i_accept (w_accept),
    .i_last   (w_last),
    .i_k      (r_k),
    .i_sample (adc1_in),
    .o_data   (out_data1)
  );

endmodule

// File: tb/tb_ltc2387_sequencer.sv
// Bench for ltc2387_sequencer: deserializer model, scoreboard of averaged outputs, frame-timing monitor.
module tb_ltc2387_sequencer;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               enable = 1'b0;
  logic [15:0]        period = 16'd100;
  logic [3:0]         log2_dec = 4'd0;
  logic               clear_timeout = 1'b0;
  logic signed [17:0] adc0_in = '0;
  logic signed [17:0] adc1_in = '0;
  logic               adc_valid_in = 1'b0;
  logic               cnv;
  logic               burst_start;
  logic signed [17:0] out_data0;
  logic signed [17:0] out_data1;
  logic               out_valid;
  logic               busy;
  logic [15:0]        timeout_cnt;

  always #5 clk = ~clk;

  ltc2387_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .period        (period),
    .log2_dec      (log2_dec),
    .clear_timeout (clear_timeout),
    .adc0_in       (adc0_in),
    .adc1_in       (adc1_in),
    .adc_valid_in  (adc_valid_in),
    .cnv           (cnv),
    .burst_start   (burst_start),
    .out_data0     (out_data0),
    .out_data1     (out_data1),
    .out_valid     (out_valid),
    .busy          (busy),
    .timeout_cnt   (timeout_cnt)
  );

  typedef struct { bit skip; bit late; int d0; int d1; } plan_t;
  typedef struct { int d0; int d1; } exp_t;

  plan_t plan_q[$];
  exp_t  exp_q[$];

  int n_checks   = 0;
  int n_fail     = 0;
  int cyc        = 0;
  int rise_cyc   = 0;
  int n_rise     = 0;
  int cnv_len    = 0;
  int chk_period = 0;
  bit have_rise  = 0;
  bit prev_cnv   = 0;
  bit prev_valid = 0;

  task automatic check(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic push_sample(input int d0, input int d1);
    plan_q.push_back('{skip: 1'b0, late: 1'b0, d0: d0, d1: d1});
  endtask

  task automatic push_skip(input bit late);
    plan_q.push_back('{skip: 1'b1, late: late, d0: 999, d1: -999});
  endtask

  task automatic expect_out(input int d0, input int d1);
    exp_q.push_back('{d0: d0, d1: d1});
  endtask

  // Deserializer model: answer each burst 12 cycles later, or withhold / answer late during HOLD.
  initial begin
    plan_t p;
    forever begin
      @(negedge clk);
      if (burst_start && !rst) begin
        if (plan_q.size() > 0) p = plan_q.pop_front();
        else                   p = '{skip: 1'b1, late: 1'b0, d0: 0, d1: 0};
        if (!p.skip || p.late) begin
          repeat (p.skip ? 40 : 12) @(posedge clk);
          #1;
          adc0_in      = 18'(p.d0);
          adc1_in      = 18'(p.d1);
          adc_valid_in = 1'b1;
          @(posedge clk);
          #1;
          adc_valid_in = 1'b0;
        end
      end
    end
  end

  // Monitor: frame timing per CNV rise, and scoreboard compare on every out_valid.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!busy) have_rise = 0;
      if (cnv && !prev_cnv) begin
        if (have_rise && chk_period != 0) check("cnv_period", cyc - rise_cyc, chk_period);
        rise_cyc  = cyc;
        have_rise = 1;
        n_rise++;
        cnv_len   = 0;
      end
      if (cnv) cnv_len++;
      if (!cnv && prev_cnv) check("cnv_width", cnv_len, 2);
      if (burst_start) check("burst_offset", cyc - rise_cyc, 16);
      if (out_valid) begin
        check("out_valid_latency", int'(prev_valid), 1);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_out: got %0d/%0d, expected no output", out_data0, out_data1);
        end else begin
          e = exp_q.pop_front();
          check("out_data0", int'(out_data0), e.d0);
          check("out_data1", int'(out_data1), e.d1);
        end
      end
      prev_cnv   = (cnv === 1'b1);
      prev_valid = (adc_valid_in === 1'b1);
    end
  end

  task automatic wait_rise(input int target, input int budget);
    int b = budget;
    while (n_rise < target && b > 0) begin
      @(negedge clk);
      #1;
      b--;
    end
    check("cnv_seen", n_rise, target);
  endtask

  task automatic wait_idle(input int budget);
    int b = budget;
    @(negedge clk);
    #1;
    while (busy && b > 0) begin
      @(negedge clk);
      #1;
      b--;
    end
    check("idle_reached", int'(busy), 0);
  endtask

  // Run exactly n frames: enable until the nth CNV rises, then let that frame finish.
  task automatic run_frames(input int n, input int per_eff);
    int start = n_rise;
    chk_period = per_eff;
    @(posedge clk);
    #1 enable = 1'b1;
    wait_rise(start + n, n * per_eff + 50);
    @(posedge clk);
    #1 enable = 1'b0;
    wait_idle(per_eff + 50);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached with %0d checks done", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    int delta;
    int b;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cnv", int'(cnv), 0);
    check("rst_burst", int'(burst_start), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_data0", int'(out_data0), 0);
    check("rst_data1", int'(out_data1), 0);
    check("rst_timeout_cnt", int'(timeout_cnt), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(negedge clk);
    check("idle_no_cnv", n_rise, 0);

    // Single-sample path, k = 0, full-scale extremes.
    period   = 16'd100;
    log2_dec = 4'd0;
    push_sample(131071, -131072); expect_out(131071, -131072);
    push_sample(100, -100);       expect_out(100, -100);
    push_sample(0, 5);            expect_out(0, 5);
    run_frames(3, 100);

    // Decimation by 4 with floor on negative means.
    log2_dec = 4'd2;
    push_sample(4, 100);  push_sample(5, 200);  push_sample(6, 300);  push_sample(7, 401);
    expect_out(5, 250);
    push_sample(-1, -8);  push_sample(-1, -8);  push_sample(-1, -8);  push_sample(-2, -9);
    expect_out(-2, -9);
    run_frames(8, 100);

    // Period clamp to 49.
    period   = 16'd10;
    log2_dec = 4'd0;
    push_sample(1, 2); expect_out(1, 2);
    push_sample(3, 4); expect_out(3, 4);
    push_sample(5, 6); expect_out(5, 6);
    run_frames(3, 49);

    // Missed frame excluded from a k=1 average; its late valid lands in HOLD.
    period   = 16'd100;
    log2_dec = 4'd1;
    push_sample(10, 20);
    push_skip(1'b1);
    push_sample(30, 40);
    expect_out(20, 30);
    run_frames(3, 100);
    check("timeout_cnt_after_miss", int'(timeout_cnt), 1);

    // clear_timeout on the exact timeout cycle (frame cycle 47) leaves the count at 1.
    start      = n_rise;
    chk_period = 100;
    @(posedge clk);
    #1 enable = 1'b1;
    wait_rise(start + 1, 200);
    @(posedge clk);
    #1 enable = 1'b0;
    repeat (46) @(posedge clk);
    #1 clear_timeout = 1'b1;
    @(posedge clk);
    #1 clear_timeout = 1'b0;
    wait_idle(200);
    check("timeout_clear_coincident", int'(timeout_cnt), 1);

    // Enable dropped during READ: frame completes, busy falls at frame cycle 60, no more CNV.
    period   = 16'd60;
    log2_dec = 4'd0;
    push_sample(7, 8); expect_out(7, 8);
    start      = n_rise;
    chk_period = 60;
    @(posedge clk);
    #1 enable = 1'b1;
    wait_rise(start + 1, 100);
    repeat (20) @(posedge clk);
    #1 enable = 1'b0;
    b = 200;
    @(negedge clk);
    #1;
    while (busy && b > 0) begin
      @(negedge clk);
      #1;
      b--;
    end
    delta = cyc - rise_cyc;
    check("stop_busy_fall", delta, 60);
    repeat (150) @(negedge clk);
    check("stop_no_more_cnv", n_rise - start, 1);

    // Reset mid-frame, held for 3 cycles.
    period     = 16'd100;
    chk_period = 100;
    start      = n_rise;
    @(posedge clk);
    #1 enable = 1'b1;
    wait_rise(start + 1, 100);
    repeat (20) @(posedge clk);
    #1;
    rst    = 1'b1;
    enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_cnv", int'(cnv), 0);
    check("midrst_burst", int'(burst_start), 0);
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_data0", int'(out_data0), 0);
    check("midrst_data1", int'(out_data1), 0);
    check("midrst_timeout_cnt", int'(timeout_cnt), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    start = n_rise;
    repeat (30) @(negedge clk);
    check("midrst_no_cnv", n_rise - start, 0);
    check("midrst_still_idle", int'(busy), 0);

    // Restart after reset with a clamped period.
    period = 16'd10;
    push_sample(-5, 5); expect_out(-5, 5);
    run_frames(1, 49);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
